// File: rtl/t02_regfile_scoreboard_if.sv
// rtl/t02_regfile_scoreboard_if.sv - write, read, busy-mark and status signals of the regfile scoreboard
interface t02_regfile_scoreboard_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic              en;
    logic              reg_write;
    logic [IDX_W-1:0]  write_index;
    logic [DATA_W-1:0] write_data;
    logic [IDX_W-1:0]  read_index1;
    logic [IDX_W-1:0]  read_index2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic              busy_set;
    logic [IDX_W-1:0]  busy_index;
    logic              hazard1;
    logic              hazard2;
    logic [IDX_W:0]    busy_count;

    modport master (
        output en, reg_write, write_index, write_data,
        output read_index1, read_index2, busy_set, busy_index,
        input  read_data1, read_data2, hazard1, hazard2, busy_count
    );

    modport slave (
        input  en, reg_write, write_index, write_data,
        input  read_index1, read_index2, busy_set, busy_index,
        output read_data1, read_data2, hazard1, hazard2, busy_count
    );
endinterface

// File: rtl/t02_regfile_scoreboard.sv
// rtl/t02_regfile_scoreboard.sv - register file with per-register pending-producer scoreboard
module t02_regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input logic                     clk,
    input logic                     nRST,
    t02_regfile_scoreboard_if.slave rf
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int CNT_W = IDX_W + 1;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [CNT_W-1:0]    busy_count;

    logic commit;
    logic set_ok;
    logic set_inc;
    logic clr_dec;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} < CNT_W'(NUM_REGS);
    endfunction

    function automatic logic writable(input logic [IDX_W-1:0] idx);
        return in_range(idx) && !(ZERO_REG && (idx == '0));
    endfunction

    function automatic logic busy_at(input logic [IDX_W-1:0] idx, input logic [NUM_REGS-1:0] b);
        return in_range(idx) ? b[idx] : 1'b0;
    endfunction

    function automatic logic [DATA_W-1:0] read_port(
        input logic [IDX_W-1:0]  idx,
        input logic              cm,
        input logic [IDX_W-1:0]  wi,
        input logic [DATA_W-1:0] wd,
        input logic [DATA_W-1:0] stored
    );
        if (!writable(idx))
            return (in_range(idx) && !ZERO_REG) ? stored : '0;
        if (BYPASS && cm && (idx == wi))
            return wd;
        return stored;
    endfunction

    function automatic logic hazard_of(
        input logic [IDX_W-1:0]    idx,
        input logic [NUM_REGS-1:0] b,
        input logic                cm,
        input logic [IDX_W-1:0]    wi
    );
        if (!writable(idx))
            return 1'b0;
        return busy_at(idx, b) & ~(BYPASS & cm & (idx == wi));
    endfunction

    // Gating commit with nRST keeps bypass from leaking write_data while reset is held.
    always_comb begin
        commit  = nRST & rf.en & rf.reg_write & writable(rf.write_index);
        set_ok  = rf.en & rf.busy_set & writable(rf.busy_index);
        set_inc = set_ok & ~busy_at(rf.busy_index, busy);
        clr_dec = commit & busy_at(rf.write_index, busy)
                & ~(set_ok & (rf.busy_index == rf.write_index));
    end

    // The busy set is issued after the commit clear so a same-index set wins.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (commit) begin
                regs[rf.write_index] <= rf.write_data;
                busy[rf.write_index] <= 1'b0;
            end
            if (set_ok)
                busy[rf.busy_index] <= 1'b1;
            busy_count <= busy_count + CNT_W'(set_inc) - CNT_W'(clr_dec);
        end
    end

    logic [DATA_W-1:0] stored1;
    logic [DATA_W-1:0] stored2;

    always_comb begin
        stored1 = in_range(rf.read_index1) ? regs[rf.read_index1] : '0;
        stored2 = in_range(rf.read_index2) ? regs[rf.read_index2] : '0;
    end

    assign rf.read_data1 = read_port(rf.read_index1, commit, rf.write_index, rf.write_data, stored1);
    assign rf.read_data2 = read_port(rf.read_index2, commit, rf.write_index, rf.write_data, stored2);
    assign rf.hazard1    = hazard_of(rf.read_index1, busy, commit, rf.write_index);
    assign rf.hazard2    = hazard_of(rf.read_index2, busy, commit, rf.write_index);
    assign rf.busy_count = busy_count;
endmodule

// File: tb/tb_t02_regfile_scoreboard.sv
// tb/tb_t02_regfile_scoreboard.sv - two configurations driven in lockstep against a reference model
module tb_t02_regfile_scoreboard;
    localparam int NREG [2] = '{32, 20};
    localparam bit BYP  [2] = '{1'b1, 1'b0};
    localparam bit ZR   [2] = '{1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        nRST;
    logic        en, rw, bs;
    logic [4:0]  wi, bi, ri1, ri2;
    logic [31:0] wd;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_regs [2][64];
    bit          m_busy [2][64];

    t02_regfile_scoreboard_if #(.DATA_W(32), .NUM_REGS(32)) ifa ();
    t02_regfile_scoreboard_if #(.DATA_W(32), .NUM_REGS(20)) ifb ();

    t02_regfile_scoreboard #(.DATA_W(32), .NUM_REGS(32), .BYPASS(1'b1), .ZERO_REG(1'b1))
        dut_a (.clk(clk), .nRST(nRST), .rf(ifa));
    t02_regfile_scoreboard #(.DATA_W(32), .NUM_REGS(20), .BYPASS(1'b0), .ZERO_REG(1'b0))
        dut_b (.clk(clk), .nRST(nRST), .rf(ifb));

    assign ifa.en = en;           assign ifb.en = en;
    assign ifa.reg_write = rw;    assign ifb.reg_write = rw;
    assign ifa.write_index = wi;  assign ifb.write_index = wi;
    assign ifa.write_data = wd;   assign ifb.write_data = wd;
    assign ifa.read_index1 = ri1; assign ifb.read_index1 = ri1;
    assign ifa.read_index2 = ri2; assign ifb.read_index2 = ri2;
    assign ifa.busy_set = bs;     assign ifb.busy_set = bs;
    assign ifa.busy_index = bi;   assign ifb.busy_index = bi;

    logic [31:0] o_rd1 [2];
    logic [31:0] o_rd2 [2];
    logic        o_hz1 [2];
    logic        o_hz2 [2];
    logic [5:0]  o_bc  [2];

    assign o_rd1[0] = ifa.read_data1; assign o_rd1[1] = ifb.read_data1;
    assign o_rd2[0] = ifa.read_data2; assign o_rd2[1] = ifb.read_data2;
    assign o_hz1[0] = ifa.hazard1;    assign o_hz1[1] = ifb.hazard1;
    assign o_hz2[0] = ifa.hazard2;    assign o_hz2[1] = ifb.hazard2;
    assign o_bc[0]  = ifa.busy_count; assign o_bc[1]  = ifb.busy_count;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(int c, logic [4:0] idx);
        return (int'(idx) < NREG[c]) && !(ZR[c] && idx == 5'd0);
    endfunction

    function automatic bit m_commit(int c);
        return nRST && en && rw && legal(c, wi);
    endfunction

    function automatic bit m_set(int c);
        return nRST && en && bs && legal(c, bi);
    endfunction

    function automatic logic [31:0] exp_read(int c, logic [4:0] ri);
        if (int'(ri) >= NREG[c]) return 32'h0;
        if (ZR[c] && ri == 5'd0) return 32'h0;
        if (BYP[c] && m_commit(c) && wi == ri) return wd;
        return m_regs[c][ri];
    endfunction

    function automatic logic exp_haz(int c, logic [4:0] ri);
        if (!legal(c, ri)) return 1'b0;
        return m_busy[c][ri] && !(BYP[c] && m_commit(c) && wi == ri);
    endfunction

    function automatic int popcount(int c);
        int n = 0;
        for (int i = 0; i < 64; i++)
            if (m_busy[c][i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 64; i++) begin
                m_regs[c][i] = 32'h0;
                m_busy[c][i] = 1'b0;
            end
    endtask

    task automatic model_edge();
        if (!nRST) begin
            model_reset();
        end else begin
            for (int c = 0; c < 2; c++) begin
                bit cm = m_commit(c);
                bit st = m_set(c);
                if (cm) begin
                    m_regs[c][wi] = wd;
                    m_busy[c][wi] = 1'b0;
                end
                if (st) m_busy[c][bi] = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string ph);
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("%s cfg%0d rd1", ph, c), o_rd1[c], exp_read(c, ri1));
            chk($sformatf("%s cfg%0d rd2", ph, c), o_rd2[c], exp_read(c, ri2));
            chk($sformatf("%s cfg%0d hz1", ph, c), o_hz1[c], exp_haz(c, ri1));
            chk($sformatf("%s cfg%0d hz2", ph, c), o_hz2[c], exp_haz(c, ri2));
            chk($sformatf("%s cfg%0d busy_count", ph, c), o_bc[c], popcount(c));
        end
    endtask

    task automatic step(input string ph);
        #1;
        check_all(ph);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        en = 1'b1; rw = 1'b0; bs = 1'b0;
        wi = '0; bi = '0; ri1 = '0; ri2 = '0; wd = '0;
    endtask

    initial begin
        nRST = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        step("reset");
        nRST = 1'b1;

        // write r5, bypass visible only on the BYPASS=1 instance
        rw = 1'b1; wi = 5'd5; wd = 32'hDEADBEEF; ri1 = 5'd5; ri2 = 5'd5;
        #1;
        chk("r5 bypass cfg0", o_rd1[0], 32'hDEADBEEF);
        chk("r5 no bypass cfg1", o_rd1[1], 32'h0);
        step("r5 write");
        idle(); ri1 = 5'd5; ri2 = 5'd5;
        #1;
        chk("r5 readback p1 cfg0", o_rd1[0], 32'hDEADBEEF);
        chk("r5 readback p2 cfg0", o_rd2[0], 32'hDEADBEEF);
        chk("r5 readback p1 cfg1", o_rd1[1], 32'hDEADBEEF);
        step("r5 read");

        rw = 1'b1; wi = 5'd0; wd = 32'h1234;
        step("r0 write");
        idle();
        #1;
        chk("r0 zero cfg0", o_rd1[0], 32'h0);
        chk("r0 busy_count cfg0", o_bc[0], 6'd0);
        chk("r0 ordinary cfg1", o_rd1[1], 32'h1234);
        step("r0 read");

        bs = 1'b1; bi = 5'd3; step("set r3");
        bi = 5'd7; step("set r7");
        idle(); ri1 = 5'd3;
        #1;
        chk("two busy cfg0", o_bc[0], 6'd2);
        chk("hazard r3 cfg0", o_hz1[0], 1'b1);
        rw = 1'b1; wi = 5'd3; wd = 32'h3333;
        #1;
        chk("commit r3 hazard cfg0", o_hz1[0], 1'b0);
        chk("commit r3 hazard cfg1", o_hz1[1], 1'b1);
        step("commit r3");
        idle();
        #1;
        chk("after r3 count cfg0", o_bc[0], 6'd1);

        bs = 1'b1; bi = 5'd9; step("set r9");
        rw = 1'b1; wi = 5'd9; wd = 32'h9999; step("set+commit r9");
        idle(); ri1 = 5'd9;
        #1;
        chk("r9 still busy cfg0", o_hz1[0], 1'b1);
        chk("r9 count cfg0", o_bc[0], 6'd2);
        chk("r9 count cfg1", o_bc[1], 6'd2);

        en = 1'b0; rw = 1'b1; wi = 5'd4; wd = 32'hAAAA; bs = 1'b1; bi = 5'd4; ri1 = 5'd4;
        step("en low");
        idle(); ri1 = 5'd4;
        #1;
        chk("r4 frozen data cfg0", o_rd1[0], 32'h0);
        chk("r4 frozen hazard cfg0", o_hz1[0], 1'b0);
        chk("r4 frozen count cfg0", o_bc[0], 6'd2);

        rw = 1'b1; wi = 5'd2; wd = 32'hFF; bs = 1'b1; bi = 5'd2;
        step("r2 write+set");
        idle(); ri1 = 5'd2; ri2 = 5'd9;
        #1;
        chk("pre-reset count cfg0", o_bc[0], 6'd3);
        chk("pre-reset r2 cfg0", o_rd1[0], 32'hFF);
        #2;
        nRST = 1'b0;
        model_reset();
        #1;
        check_all("async reset");
        @(negedge clk);
        rw = 1'b1; wi = 5'd6; wd = 32'h6666; bs = 1'b1; bi = 5'd6; ri1 = 5'd6; ri2 = 5'd2;
        step("reset hold");
        idle();
        nRST = 1'b1;
        step("after reset");

        for (int k = 0; k < 400; k++) begin
            en  = ($urandom_range(0, 7) != 0);
            rw  = $urandom_range(0, 1);
            wi  = 5'($urandom_range(0, 31));
            wd  = $urandom;
            bs  = ($urandom_range(0, 2) == 0);
            bi  = ($urandom_range(0, 3) == 0) ? wi : 5'($urandom_range(0, 31));
            ri1 = ($urandom_range(0, 2) == 0) ? wi : 5'($urandom_range(0, 31));
            ri2 = ($urandom_range(0, 2) == 0) ? bi : 5'($urandom_range(0, 31));
            step("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
